// File: rtl/tow_pkg.sv
// tow_pkg: shared constants and helpers for the tug-of-war score keeper.
//   - led_control codes as issued by the mc game controller
//   - rope position constants (0 = left end, 6 = right end)
//   - winner encoding and small LED / score helper functions
package tow_pkg;

  localparam logic [2:0] LC_DARK    = 3'b000;
  localparam logic [2:0] LC_RESET   = 3'b001;
  localparam logic [2:0] LC_ALL     = 3'b010;
  localparam logic [2:0] LC_SCORE   = 3'b011;
  localparam logic [2:0] LC_FAKE    = 3'b100;
  localparam logic [2:0] LC_SPEED   = 3'b110;
  localparam logic [2:0] LC_VICTORY = 3'b111;

  localparam logic [2:0] POS_LEFT   = 3'd0;
  localparam logic [2:0] POS_CENTRE = 3'd3;
  localparam logic [2:0] POS_RIGHT  = 3'd6;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } winner_t;

  // End LED belonging to a side (bit 0 = left end).
  function automatic logic [6:0] end_led(input winner_t w);
    case (w)
      LEFT:    return 7'b0000001;
      RIGHT:   return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  // Half of the bar belonging to a side, used for the victory display.
  function automatic logic [6:0] half_led(input winner_t w);
    case (w)
      LEFT:    return 7'b0000111;
      RIGHT:   return 7'b1110000;
      default: return 7'b0000000;
    endcase
  endfunction

  // Score plus up to two single-point awards, saturating at 3.
  function automatic logic [1:0] score_add(input logic [1:0] s, input logic a, input logic b);
    logic [2:0] sum;
    sum = {1'b0, s} + {2'b00, a} + {2'b00, b};
    return (sum > 3'd3) ? 2'd3 : sum[1:0];
  endfunction

endpackage

// File: rtl/tow_score_keeper_speed_counter.sv
// speed_counter: per-player press counter for the speed round.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   zero        - synchronous clear (has priority over everything else)
//   freeze      - hold the count (round decided or no speed round running)
//   press       - one-cycle button pulse
//   reached     - the count being loaded this cycle is >= SPEED_TARGET
// The counter is 4 bits and saturates at 15.
module speed_counter #(
  parameter int SPEED_TARGET = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic zero,
  input  logic freeze,
  input  logic press,
  output logic reached
);

  localparam logic [3:0] TARGET = 4'(SPEED_TARGET);

  logic [3:0] count;
  logic [3:0] count_next;

  always_comb begin
    count_next = count;
    if (zero) begin
      count_next = 4'd0;
    end else if (!freeze && press && (count != 4'hf)) begin
      count_next = count + 4'd1;
    end
  end

  // Looking at the next value lets the top decide the race on the same
  // edge that registers the winning press, so the loser's later presses
  // are already frozen out.
  assign reached = (count_next >= TARGET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/tow_score_keeper.sv
// tow_score_keeper: player-side companion of the mc game controller.
// Moves the rope, keeps round and speed-round tallies, drives the LED bar
// and returns the status flags mc sequences on.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   pbl, pbr              - left/right button pulses
//   slowen                - slow tick strobe
//   leds_on, clear, fake, speed_round, led_control[2:0] - from mc
//   leds[6:0]             - LED bar, bit 0 = left end
//   winrnd, winspeed      - round won / speed round decided (levels)
//   speed_exit            - one-cycle pulse ending the speed result display
//   Victory               - sticky game-won flag
//   score_l, score_r      - saturating round-win counts
// Build option: define TOW_FALSE_START_EN to make presses during the dark
// phase push the rope toward the opponent (and possibly win the round);
// without it, presses in the dark are ignored.
module tow_score_keeper #(
  parameter int SPEED_TARGET  = 10,
  parameter int WIN_ROUNDS    = 3,
  parameter int DISPLAY_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pbl,
  input  logic       pbr,
  input  logic       slowen,
  input  logic       leds_on,
  input  logic       clear,
  input  logic       fake,
  input  logic       speed_round,
  input  logic [2:0] led_control,
  output logic [6:0] leds,
  output logic       winrnd,
  output logic       winspeed,
  output logic       speed_exit,
  output logic       Victory,
  output logic [1:0] score_l,
  output logic [1:0] score_r
);
  import tow_pkg::*;

  localparam logic [7:0] DISP_LAST = 8'(DISPLAY_TICKS - 1);
  localparam logic [1:0] WIN_LIMIT = 2'(WIN_ROUNDS);

  logic [2:0] pos;
  logic [2:0] pos_next;
  winner_t    last_winner;
  logic       speed_round_q;
  logic       spd_l;
  logic       spd_r;
  logic       vic_phase;
  logic [7:0] disp_cnt;
  logic [6:0] leds_next;

  logic move_en;
  logic reversed;
  logic step_up;
  logic step_down;
  logic round_win_l;
  logic round_win_r;
  logic sr_rise;
  logic sr_fall;
  logic spd_freeze;
  logic reach_l;
  logic reach_r;
  logic speed_decide;
  logic spd_win_l;
  logic spd_win_r;

  // Which phases let buttons move the rope, and in which direction.
  always_comb begin
    move_en  = 1'b0;
    reversed = 1'b0;
    if (fake) begin
      move_en  = 1'b1;
      reversed = 1'b1;
    end else if (led_control == LC_SCORE) begin
      move_en = 1'b1;
`ifdef TOW_FALSE_START_EN
    end else if (led_control == LC_DARK) begin
      move_en  = 1'b1;
      reversed = 1'b1;
`endif
    end
  end

  // Simultaneous presses cancel out.
  assign step_up   = move_en && (pbl ^ pbr) && (reversed ? pbl : pbr);
  assign step_down = move_en && (pbl ^ pbr) && (reversed ? pbr : pbl);

  always_comb begin
    pos_next = pos;
    if (clear) begin
      pos_next = POS_CENTRE;
    end else if (!winrnd) begin
      if (step_up && (pos != POS_RIGHT)) begin
        pos_next = pos + 3'd1;
      end else if (step_down && (pos != POS_LEFT)) begin
        pos_next = pos - 3'd1;
      end
    end
  end

  // pos only reaches an end through a move, and that move sets winrnd,
  // so an end position with winrnd low only ever means a fresh win.
  assign round_win_l = !clear && !winrnd && (pos_next == POS_LEFT);
  assign round_win_r = !clear && !winrnd && (pos_next == POS_RIGHT);

  assign sr_rise    = speed_round && !speed_round_q;
  assign sr_fall    = !speed_round && speed_round_q;
  assign spd_freeze = winspeed || !speed_round;

  speed_counter #(.SPEED_TARGET(SPEED_TARGET)) u_cnt_l (
    .clk     (clk),
    .rst_n   (rst_n),
    .zero    (sr_rise),
    .freeze  (spd_freeze),
    .press   (pbl),
    .reached (reach_l)
  );

  speed_counter #(.SPEED_TARGET(SPEED_TARGET)) u_cnt_r (
    .clk     (clk),
    .rst_n   (rst_n),
    .zero    (sr_rise),
    .freeze  (spd_freeze),
    .press   (pbr),
    .reached (reach_r)
  );

  assign speed_decide = speed_round && !winspeed && (reach_l || reach_r);
  // A tie decides the round but awards nobody.
  assign spd_win_l    = speed_decide && reach_l && !reach_r;
  assign spd_win_r    = speed_decide && reach_r && !reach_l;

  always_comb begin
    leds_next = 7'd0;
    case (led_control)
      LC_DARK:    leds_next = 7'd0;
      LC_RESET:   leds_next = 7'b0001000;
      LC_ALL:     leds_next = 7'b1111111;
      LC_SCORE:   leds_next = clear ? end_led(last_winner) : (7'd1 << pos);
      LC_FAKE:    leds_next = 7'd1 << pos;
      LC_SPEED:   leds_next = (spd_l || spd_r) ? {spd_r, 5'd0, spd_l} : 7'b0001000;
      LC_VICTORY: leds_next = vic_phase ? 7'd0 : half_led(last_winner);
      default:    leds_next = 7'd0;
    endcase
    if (!leds_on) begin
      leds_next = 7'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos           <= POS_CENTRE;
      winrnd        <= 1'b0;
      last_winner   <= NONE;
      score_l       <= 2'd0;
      score_r       <= 2'd0;
      speed_round_q <= 1'b0;
      winspeed      <= 1'b0;
      spd_l         <= 1'b0;
      spd_r         <= 1'b0;
      Victory       <= 1'b0;
      disp_cnt      <= 8'd0;
      speed_exit    <= 1'b0;
      vic_phase     <= 1'b0;
      leds          <= 7'd0;
    end else begin
      pos           <= pos_next;
      speed_round_q <= speed_round;
      leds          <= leds_next;

      if (clear) begin
        winrnd <= 1'b0;
      end else if (round_win_l || round_win_r) begin
        winrnd <= 1'b1;
      end

      score_l <= score_add(score_l, round_win_l, spd_win_l);
      score_r <= score_add(score_r, round_win_r, spd_win_r);

      if (round_win_l) begin
        last_winner <= LEFT;
      end else if (round_win_r) begin
        last_winner <= RIGHT;
      end else if (spd_win_l) begin
        last_winner <= LEFT;
      end else if (spd_win_r) begin
        last_winner <= RIGHT;
      end

      if (sr_fall) begin
        winspeed <= 1'b0;
      end else if (speed_decide) begin
        winspeed <= 1'b1;
      end

      // Speed result survives the end of speed_round so the display phase
      // can still show it; it is forgotten when the next speed round starts.
      if (sr_rise) begin
        spd_l <= 1'b0;
        spd_r <= 1'b0;
      end else if (speed_decide) begin
        spd_l <= reach_l;
        spd_r <= reach_r;
      end

      // Looks at the registered scores, hence one cycle behind them.
      Victory <= Victory || (score_l >= WIN_LIMIT) || (score_r >= WIN_LIMIT);

      if (led_control != LC_SPEED) begin
        disp_cnt   <= 8'd0;
        speed_exit <= 1'b0;
      end else if (!speed_round && slowen) begin
        if (disp_cnt == DISP_LAST) begin
          disp_cnt   <= 8'd0;
          speed_exit <= 1'b1;
        end else begin
          disp_cnt   <= disp_cnt + 8'd1;
          speed_exit <= 1'b0;
        end
      end else begin
        speed_exit <= 1'b0;
      end

      // Blink phase restarts lit each time the victory display is entered.
      if (led_control != LC_VICTORY) begin
        vic_phase <= 1'b0;
      end else if (slowen) begin
        vic_phase <= !vic_phase;
      end
    end
  end

endmodule

// File: tb/tb_tow_score_keeper.sv
// tb_tow_score_keeper: directed scenarios with literal expectations plus a
// randomized phase run, all checked every cycle against a behavioural model.
module tb_tow_score_keeper;

  localparam int T_SPEED = 10;
  localparam int T_WIN   = 3;
  localparam int T_DISP  = 4;
`ifdef TOW_FALSE_START_EN
  localparam bit FSE = 1'b1;
`else
  localparam bit FSE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pbl = 1'b0;
  logic       pbr = 1'b0;
  logic       slowen = 1'b0;
  logic       leds_on = 1'b0;
  logic       clear = 1'b0;
  logic       fake = 1'b0;
  logic       speed_round = 1'b0;
  logic [2:0] led_control = 3'd0;
  logic [6:0] leds;
  logic       winrnd;
  logic       winspeed;
  logic       speed_exit;
  logic       Victory;
  logic [1:0] score_l;
  logic [1:0] score_r;

  always #5 clk = ~clk;

  tow_score_keeper #(
    .SPEED_TARGET  (T_SPEED),
    .WIN_ROUNDS    (T_WIN),
    .DISPLAY_TICKS (T_DISP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pbl         (pbl),
    .pbr         (pbr),
    .slowen      (slowen),
    .leds_on     (leds_on),
    .clear       (clear),
    .fake        (fake),
    .speed_round (speed_round),
    .led_control (led_control),
    .leds        (leds),
    .winrnd      (winrnd),
    .winspeed    (winspeed),
    .speed_exit  (speed_exit),
    .Victory     (Victory),
    .score_l     (score_l),
    .score_r     (score_r)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural model ----------------
  // Rope as a signed integer, winners as 0 none / 1 left / 2 right.
  int m_pos, m_winrnd, m_lw, m_sl, m_sr, m_winspeed, m_exit, m_vic, m_leds;
  int m_cl, m_cr, m_srq, m_disp, m_phase, m_spl, m_spr;

  task automatic model_reset();
    m_pos = 3; m_winrnd = 0; m_lw = 0; m_sl = 0; m_sr = 0; m_winspeed = 0;
    m_exit = 0; m_vic = 0; m_leds = 0; m_cl = 0; m_cr = 0; m_srq = 0;
    m_disp = 0; m_phase = 0; m_spl = 0; m_spr = 0;
  endtask

  task automatic model_step();
    int  dir, rwin, swin, n_pos, n_cl, n_cr, n_leds, n_vic;
    bit  rise, fall;
    // LED bar from the state before this edge
    case (led_control)
      3'd1:    n_leds = 8;
      3'd2:    n_leds = 127;
      3'd3:    n_leds = clear ? (m_lw == 1 ? 1 : (m_lw == 2 ? 64 : 0)) : (1 << m_pos);
      3'd4:    n_leds = 1 << m_pos;
      3'd6:    n_leds = (m_spl != 0 || m_spr != 0) ? ((m_spl != 0 ? 1 : 0) + (m_spr != 0 ? 64 : 0)) : 8;
      3'd7:    n_leds = (m_phase != 0) ? 0 : (m_lw == 1 ? 7 : (m_lw == 2 ? 112 : 0));
      default: n_leds = 0;
    endcase
    if (!leds_on) n_leds = 0;
    n_vic = (m_vic != 0 || m_sl >= T_WIN || m_sr >= T_WIN) ? 1 : 0;

    // rope
    dir = 0;
    if (pbl && !pbr) dir = -1;
    else if (pbr && !pbl) dir = 1;
    if (fake) dir = -dir;
    else if (led_control != 3'd3) dir = (led_control == 3'd0 && FSE) ? -dir : 0;
    rwin = 0;
    n_pos = m_pos;
    if (clear) n_pos = 3;
    else if (m_winrnd == 0) begin
      n_pos = m_pos + dir;
      if (n_pos < 0) n_pos = 0;
      if (n_pos > 6) n_pos = 6;
      if (n_pos == 0) rwin = 1;
      else if (n_pos == 6) rwin = 2;
    end

    // speed race
    rise = speed_round && (m_srq == 0);
    fall = !speed_round && (m_srq != 0);
    n_cl = m_cl;
    n_cr = m_cr;
    if (rise) begin
      n_cl = 0;
      n_cr = 0;
    end else if (speed_round && m_winspeed == 0) begin
      n_cl = (m_cl + int'(pbl) > 15) ? 15 : m_cl + int'(pbl);
      n_cr = (m_cr + int'(pbr) > 15) ? 15 : m_cr + int'(pbr);
    end
    swin = 0;
    if (speed_round && !rise && m_winspeed == 0 && (n_cl >= T_SPEED || n_cr >= T_SPEED))
      swin = (n_cl >= T_SPEED ? 1 : 0) + (n_cr >= T_SPEED ? 2 : 0);

    // display counter and blink phase
    if (led_control != 3'd6) begin
      m_disp = 0;
      m_exit = 0;
    end else if (!speed_round && slowen) begin
      m_disp++;
      if (m_disp == T_DISP) begin
        m_disp = 0;
        m_exit = 1;
      end else m_exit = 0;
    end else m_exit = 0;
    if (led_control != 3'd7) m_phase = 0;
    else if (slowen) m_phase = 1 - m_phase;

    // commit
    if (clear) m_winrnd = 0;
    else if (rwin != 0) m_winrnd = 1;
    m_sl += (rwin == 1 ? 1 : 0) + (swin == 1 ? 1 : 0);
    m_sr += (rwin == 2 ? 1 : 0) + (swin == 2 ? 1 : 0);
    if (m_sl > 3) m_sl = 3;
    if (m_sr > 3) m_sr = 3;
    if (rwin != 0) m_lw = rwin;
    else if (swin == 1 || swin == 2) m_lw = swin;
    if (fall) m_winspeed = 0;
    else if (swin != 0) m_winspeed = 1;
    if (rise) begin
      m_spl = 0;
      m_spr = 0;
    end else if (swin != 0) begin
      m_spl = swin & 1;
      m_spr = (swin >> 1) & 1;
    end
    m_pos = n_pos; m_cl = n_cl; m_cr = n_cr; m_srq = int'(speed_round);
    m_leds = n_leds; m_vic = n_vic;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("leds",       int'(leds),       m_leds);
    check("winrnd",     int'(winrnd),     m_winrnd);
    check("winspeed",   int'(winspeed),   m_winspeed);
    check("speed_exit", int'(speed_exit), m_exit);
    check("Victory",    int'(Victory),    m_vic);
    check("score_l",    int'(score_l),    m_sl);
    check("score_r",    int'(score_r),    m_sr);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic cyc(input bit l, input bit r, input bit s);
    pbl = l;
    pbr = r;
    slowen = s;
    step();
    pbl = 1'b0;
    pbr = 1'b0;
    slowen = 1'b0;
  endtask

  // Asserts reset between edges and checks the outputs before any edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exits;
    int code;
    int len;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_leds", int'(leds), 0);
    check("rst_scores", int'({score_l, score_r}), 0);
    rst_n = 1'b1;

    // play: three left presses win the round, a fourth is dropped
    leds_on = 1'b1;
    led_control = 3'd3;
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    check("centre_leds", int'(leds), 8);
    repeat (3) cyc(1, 0, 0);
    check("lw_winrnd", int'(winrnd), 1);
    check("lw_score_l", int'(score_l), 1);
    step();
    check("lw_leds", int'(leds), 1);
    cyc(1, 0, 0);
    step();
    check("lw_hold_score", int'(score_l), 1);
    check("lw_hold_leds", int'(leds), 1);

    // fake: left presses push right
    clear = 1'b1;
    step();
    clear = 1'b0;
    led_control = 3'd4;
    fake = 1'b1;
    repeat (3) cyc(1, 0, 0);
    check("fake_score_r", int'(score_r), 1);
    check("fake_winrnd", int'(winrnd), 1);
    step();
    check("fake_leds", int'(leds), 64);
    fake = 1'b0;
    led_control = 3'd3;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_end_led", int'(leds), 64);

    // speed round: right 10 against left 9
    led_control = 3'd6;
    speed_round = 1'b1;
    step();
    for (int i = 0; i < 10; i++) cyc(i < 9, 1'b1, 1'b0);
    check("spd_winspeed", int'(winspeed), 1);
    check("spd_score_r", int'(score_r), 2);
    speed_round = 1'b0;
    step();
    check("spd_fall", int'(winspeed), 0);
    check("spd_leds", int'(leds), 64);
    exits = 0;
    for (int i = 0; i < T_DISP; i++) begin
      cyc(0, 0, 1);
      if (speed_exit) exits++;
      step();
      if (speed_exit) exits++;
    end
    check("spd_exit_count", exits, 1);

    // speed tie
    speed_round = 1'b1;
    step();
    repeat (10) cyc(1, 1, 0);
    check("tie_winspeed", int'(winspeed), 1);
    check("tie_scores", int'({score_l, score_r}), 6);
    step();
    check("tie_leds", int'(leds), 65);
    speed_round = 1'b0;
    step();

    // two more left wins reach victory
    led_control = 3'd3;
    for (int w = 0; w < 2; w++) begin
      clear = 1'b1;
      step();
      clear = 1'b0;
      repeat (3) cyc(1, 0, 0);
    end
    check("vic_score_l", int'(score_l), 3);
    check("vic_lag", int'(Victory), 0);
    step();
    check("vic_set", int'(Victory), 1);
    led_control = 3'd7;
    step();
    check("vic_leds_on", int'(leds), 7);
    cyc(0, 0, 1);
    step();
    check("vic_leds_off", int'(leds), 0);
    cyc(0, 0, 1);
    step();
    check("vic_leds_back", int'(leds), 7);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("vic_sticky", int'(Victory), 1);

    // reset mid-move, then a dark-phase press
    led_control = 3'd3;
    pbl = 1'b1;
    async_reset();
    pbl = 1'b0;
    check("mid_rst_victory", int'(Victory), 0);
    check("mid_rst_score", int'(score_l), 0);
    led_control = 3'd0;
    cyc(1, 0, 0);
    led_control = 3'd3;
    step();
    check("dark_leds", int'(leds), FSE ? 16 : 8);

    // randomized phases
    for (int ph = 0; ph < 160; ph++) begin
      code = $urandom_range(0, 7);
      led_control = 3'(code);
      fake = (code == 4) && ($urandom_range(0, 3) != 0);
      speed_round = (code == 6);
      leds_on = ($urandom_range(0, 9) != 0);
      len = (code == 6) ? $urandom_range(20, 44) : $urandom_range(5, 30);
      for (int c = 0; c < len; c++) begin
        clear = ($urandom_range(0, 15) == 0);
        if (code == 6 && c == len / 2) speed_round = 1'b0;
        if (code == 6) begin
          pbl = ($urandom_range(0, 3) != 0);
          pbr = ($urandom_range(0, 3) != 0);
        end else begin
          pbl = 1'($urandom_range(0, 1));
          pbr = 1'($urandom_range(0, 1));
        end
        slowen = ($urandom_range(0, 3) == 0);
        step();
        pbl = 1'b0;
        pbr = 1'b0;
        slowen = 1'b0;
      end
      clear = 1'b0;
      fake = 1'b0;
      speed_round = 1'b0;
      if ($urandom_range(0, 19) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
